// File: rtl/ctrl_pipe.sv
// Control pipeline for the 5-stage MIPS core: ID/EX, EX/MEM, MEM/WB control registers,
// RAW hazard stall, branch/jump PC select. Define CTRL_PIPE_FORWARD_EN to enable EX forwarding.
module ctrl_pipe #(
  parameter int REG_W   = 5,
  parameter int ALUOP_W = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               id_RegWrite,
  input  logic               id_MemtoReg,
  input  logic               id_MemWrite,
  input  logic               id_MemRead,
  input  logic               id_RegDst,
  input  logic               id_ALUSrc,
  input  logic               id_Jump,
  input  logic               id_Brancheq,
  input  logic               id_Branchne,
  input  logic [ALUOP_W-1:0] id_ALUOP,
  input  logic [REG_W-1:0]   id_rs,
  input  logic [REG_W-1:0]   id_rt,
  input  logic [REG_W-1:0]   id_rd,
  input  logic               ex_zero,
  output logic [ALUOP_W-1:0] ex_ALUOP,
  output logic               ex_ALUSrc,
  output logic [REG_W-1:0]   ex_rs,
  output logic [REG_W-1:0]   ex_rt,
  output logic               mem_MemRead,
  output logic               mem_MemWrite,
  output logic               wb_RegWrite,
  output logic               wb_MemtoReg,
  output logic [REG_W-1:0]   wb_dest,
  output logic [1:0]         forward_a,
  output logic [1:0]         forward_b,
  output logic               stall,
  output logic               pc_write,
  output logic               ifid_write,
  output logic               if_flush,
  output logic [1:0]         pc_src
);

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10
  } pcSel_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwdSel_t;

  // ID/EX state not exported directly
  logic             exRegWrite, exMemtoReg, exMemWrite, exMemRead;
  logic             exBrancheq, exBranchne;
  logic [REG_W-1:0] exDest;

  // EX/MEM state not exported directly
  logic             memRegWrite, memMemtoReg;
  logic [REG_W-1:0] memDest;

  logic   idUsesRt, exMatch, memMatch, exTaken, rawStall, bubble;
  pcSel_t pcSel;

  function automatic logic hitsId(input logic rw, input logic [REG_W-1:0] dest,
                                  input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                                  input logic usesRt);
    return rw && (dest != '0) && ((dest == rs) || (usesRt && (dest == rt)));
  endfunction

  assign idUsesRt = ~id_ALUSrc | id_MemWrite | id_Brancheq | id_Branchne;
  assign exMatch  = hitsId(exRegWrite, exDest, id_rs, id_rt, idUsesRt);
  assign memMatch = hitsId(memRegWrite, memDest, id_rs, id_rt, idUsesRt);
  assign exTaken  = (exBrancheq & ex_zero) | (exBranchne & ~ex_zero);

`ifdef CTRL_PIPE_FORWARD_EN
  function automatic fwdSel_t fwdPick(input logic [REG_W-1:0] src);
    if (memRegWrite && (memDest != '0) && (memDest == src))
      return FWD_MEM;
    else if (wb_RegWrite && (wb_dest != '0) && (wb_dest == src))
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

  assign rawStall  = exMemRead & exMatch;
  assign forward_a = fwdPick(ex_rs);
  assign forward_b = fwdPick(ex_rt);
`else
  assign rawStall  = exMatch | memMatch;
  assign forward_a = FWD_RF;
  assign forward_b = FWD_RF;
`endif

  // A taken branch overrides both the stall and any jump sitting in ID.
  always_comb begin
    stall      = 1'b0;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    if_flush   = 1'b0;
    bubble     = 1'b0;
    pcSel      = PC_SEQ;
    if (exTaken) begin
      pcSel    = PC_BRANCH;
      if_flush = 1'b1;
      bubble   = 1'b1;
    end else if (rawStall) begin
      stall      = 1'b1;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      bubble     = 1'b1;
    end else if (id_Jump) begin
      pcSel    = PC_JUMP;
      if_flush = 1'b1;
    end
  end

  assign pc_src = pcSel;

  always_ff @(posedge clk) begin
    if (reset || bubble) begin
      exRegWrite <= 1'b0;
      exMemtoReg <= 1'b0;
      exMemWrite <= 1'b0;
      exMemRead  <= 1'b0;
      exBrancheq <= 1'b0;
      exBranchne <= 1'b0;
      exDest     <= '0;
      ex_ALUOP   <= '0;
      ex_ALUSrc  <= 1'b0;
      ex_rs      <= '0;
      ex_rt      <= '0;
    end else begin
      exRegWrite <= id_RegWrite;
      exMemtoReg <= id_MemtoReg;
      exMemWrite <= id_MemWrite;
      exMemRead  <= id_MemRead;
      exBrancheq <= id_Brancheq;
      exBranchne <= id_Branchne;
      exDest     <= id_RegDst ? id_rd : id_rt;
      ex_ALUOP   <= id_ALUOP;
      ex_ALUSrc  <= id_ALUSrc;
      ex_rs      <= id_rs;
      ex_rt      <= id_rt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      memRegWrite  <= 1'b0;
      memMemtoReg  <= 1'b0;
      memDest      <= '0;
      mem_MemRead  <= 1'b0;
      mem_MemWrite <= 1'b0;
      wb_RegWrite  <= 1'b0;
      wb_MemtoReg  <= 1'b0;
      wb_dest      <= '0;
    end else begin
      memRegWrite  <= exRegWrite;
      memMemtoReg  <= exMemtoReg;
      memDest      <= exDest;
      mem_MemRead  <= exMemRead;
      mem_MemWrite <= exMemWrite;
      wb_RegWrite  <= memRegWrite;
      wb_MemtoReg  <= memMemtoReg;
      wb_dest      <= memDest;
    end
  end

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Downstream consumer of the ID-stage control bundle from the opcode decoder in the 5-stage MIPS pipeline.
- Carries each control field through ID/EX, EX/MEM and MEM/WB registers and delivers stage-local controls.
- Detects RAW hazards and drives stall, bubble and flush for the pipeline.
- Resolves beq/bne in EX and jump in ID, and drives PC source select.

Parameters:
- REG_W, 5, register specifier width.
- ALUOP_W, 2, ALUOP field width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  synchronous, active-high; clears all stage registers.
- id_RegWrite, id_MemtoReg, id_MemWrite, id_MemRead, id_RegDst, id_ALUSrc, id_Jump, id_Brancheq, id_Branchne  in  1 each  decoded controls for the ID instruction.
- id_ALUOP  in  ALUOP_W  decoded ALU op class.
- id_rs, id_rt, id_rd  in  REG_W  ID instruction register fields.
- ex_zero  in  1  ALU zero flag of the EX instruction.
- ex_ALUOP  out  ALUOP_W; ex_ALUSrc  out  1.
- ex_rs, ex_rt  out  REG_W  EX operand specifiers.
- mem_MemRead, mem_MemWrite  out  1.
- wb_RegWrite, wb_MemtoReg  out  1; wb_dest  out  REG_W.
- forward_a, forward_b  out  2  EX operand source: 00 regfile, 10 EX/MEM, 01 MEM/WB.
- stall  out  1  load-use/RAW stall (combinational).
- pc_write, ifid_write  out  1  PC and IF/ID enables.
- if_flush  out  1  squash IF/ID on next edge.
- pc_src  out  2  00 PC+4, 01 branch target, 10 jump target.

Behaviour:
- All stage registers update on posedge clk. When reset=1 at an edge, every stage register loads 0, including in-flight instructions mid-pipeline.
- After reset, all registered outputs are 0; stall=0, pc_write=1, ifid_write=1, if_flush=0, pc_src=00, forward_a=forward_b=00.
- ID/EX capture: dest = id_RegDst ? id_rd : id_rt; the remaining controls are copied.
- Latency: ID->EX 1 cycle, ->MEM 2 cycles, ->WB 3 cycles.
- Bubble: every ID/EX control and dest is written 0.
- id_uses_rt = ~id_ALUSrc | id_MemWrite | id_Brancheq | id_Branchne.
- Hazard match: X matches ID when X_RegWrite, X_dest!=0, and (X_dest==id_rs or (id_uses_rt and X_dest==id_rt)).
- ex_taken = (ex_Brancheq & ex_zero) | (ex_Branchne & ~ex_zero).
- When ex_taken:
  - pc_src=01 and if_flush=1.
  - ID/EX gets a bubble.
  - stall is forced to 0; pc_write=1 and ifid_write=1.
  - id_Jump is ignored.
- Else if stall: ID/EX gets a bubble, pc_write=0, ifid_write=0, pc_src=00.
- Else if id_Jump: pc_src=10, if_flush=1.
- Else: normal advance, pc_src=00.
- Priority is branch flush > stall > jump.
- EX/MEM and MEM/WB always advance; they are never stalled.
- The $0 destination never matches and never forwards.
- MEM/WB-stage register writes are visible to ID in the same cycle (regfile write-first). No WB-stage hazard is ever reported.

Optional Feature:
- Macro: CTRL_PIPE_FORWARD_EN.
- Defined:
  - stall=1 only when the EX instruction is a load (ex_MemRead) and it matches ID.
  - forward_a is 10 if the MEM instruction matches ex_rs, else 01 if the WB instruction matches ex_rs, else 00. Match means RegWrite, dest!=0 and dest equal.
  - forward_b uses the same rule with ex_rt.
- Undefined:
  - forward_a and forward_b are tied to 00.
  - stall=1 whenever the EX or MEM instruction matches ID, regardless of load.

Test Plan:
- Reset held 2 cycles with nonzero id_* inputs -> all outputs 0, pc_write=1; first instruction appears at wb_* exactly 3 edges after reset deasserts.
- With FORWARD_EN: "lw $2" followed by "add $3,$2,$4" -> stall=1 for exactly 1 cycle and a bubble in EX; on the add's EX cycle forward_a=01.
- With FORWARD_EN: "add $5" followed by "sub $6,$1,$5" -> stall=0, forward_b=10 in the sub's EX cycle. Destination $0 -> forward_b=00.
- Without FORWARD_EN: same add/sub sequence -> stall=1 for 2 cycles, then forwarding outputs 00.
- beq in EX with ex_zero=1 while the ID instruction is a load-use hazard -> stall=0, if_flush=1, pc_src=01, bubble in EX next cycle. Same case with bne -> no flush, stall=1.
- Jump in ID -> pc_src=10, if_flush=1 for 1 cycle. Jump in ID while the EX beq is taken -> pc_src=01, jump ignored.
